psram_spi_responder: RTL
========================

// Module: psram_spi_responder
// PURPOSE
//  SPI-side responder emulating an IPS6404L-SQ PSRAM (1-line SPI, mode 0) over an internal byte array.
//  Sits opposite psram_* controllers: on-board loopback target and synthesizable bench model.
//  Decodes the command, 24-bit address, optional wait and data phases, and answers on SO.
// PARAMETERS
//  ADDR_BITS  10         log2 of array bytes; address bits above ADDR_BITS ignored
//  EID        48'h0      48-bit EID returned by READ_ID after MFID/KGD
//  MFID       8'h0D      manufacturer ID byte
//  KGD        8'h5D      known-good-die byte
// PORTS
//  sysclk       in   1  system clock; must be >= 8x psram_sclk
//  reset_n      in   1  asynchronous, active-low reset
//  psram_sclk   in   1  SPI clock from controller (asynchronous to sysclk)
//  psram_ce_n   in   1  chip enable, active low
//  psram_si     in   1  serial data in (SIO0)
//  psram_so     out  1  serial data out (SIO1)
//  psram_so_oe  out  1  SO output enable; high only in data-out phases
//  soft_reset   out  1  one-sysclk pulse on accepted 0x66->0x99 sequence
//  cmd_error    out  1  one-sysclk pulse when an unsupported opcode is received
//  busy         out  1  high while ce_n (synchronized) is low
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, reset-armed flag 0; array contents undefined (not cleared).
//  Inputs pass 2-FF sync; sclk_rise/sclk_fall from sync stages 2/3. Output change lags sclk fall by 3 sysclk.
//  Sample SI on sclk_rise, MSB first; update SO on sclk_fall.
//  FSM: IDLE -> CMD (8 bits) -> ADDR (24) -> [WAIT 8 clk] -> DIN | DOUT; unsupported -> IGNORE.
//   0x03 READ: ADDR -> DOUT.  0x0B FAST_READ: ADDR -> WAIT (8 rises) -> DOUT.
//   0x02 WRITE: ADDR -> DIN.  0x9F READ_ID: ADDR (dummy) -> DOUT sequence MFID, KGD, EID[47:0] MSB first,
//     then restarts at MFID.
//   0x66: set armed; stay IGNORE. 0x99 with armed: pulse soft_reset, clear armed. Any other opcode clears armed.
//   Other opcodes: pulse cmd_error, IGNORE until ce_n high; so_oe stays 0.
//  Read pipeline: array read issued on the rise of last ADDR/WAIT bit (1-cycle sync RAM);
//   shift register loads and so_oe asserts on the following sclk_fall; MSB valid before next rise.
//   Next byte prefetched on 8th bit rise of each byte; address += 1 per byte.
//  Write: byte committed on its 8th rise; address += 1. Partial byte at ce_n rise discarded.
//  Address wrap: modulo 2^ADDR_BITS.
//  ce_n high (synced) at any point: abort to IDLE next sysclk, so_oe=0, bit counters cleared; armed flag kept.
//  sclk edges while ce_n high ignored. reset_n low mid-transfer: immediate IDLE, pending write lost.
//  busy follows synced ce_n with 0 extra latency beyond sync.
// CONFIGURATION
//  PSRAM_RESP_PAGE_WRAP_EN: defined -> READ/WRITE bursts wrap within 1 KB page (addr[9:0] increments,
//   upper bits held), as the real device. Undefined -> linear increment over whole array.
//   With ADDR_BITS <= 10 both builds behave identically.
// STRUCTURE
//  psram_pkg: opcode constants (0x03,0x0B,0x02,0x9F,0x66,0x99), FSM state typedef, WAIT_CYCLES=8.
//  Sub-module spi_edge_sync: 2-FF synchronizers for sclk/ce_n/si plus rise/fall pulse generation.
//  Array: inferred sync single-port RAM inside responder; one write or read per sysclk.
// TESTING
//  1 WRITE 0x02, addr 0x000010, data A5 3C; READ 0x03 same addr -> SO shifts A5 then 3C, so_oe high only in data.
//  2 FAST_READ 0x0B at 0x000011 -> 8 wait clocks with so_oe=0, then 3C on SO.
//  3 READ_ID 0x9F + 3 dummy bytes, read 9 bytes -> 0D 5D EID bytes, 9th byte 0D.
//  4 0x66, ce_n pulse, 0x99 -> soft_reset single pulse; 0x99 alone or 0x66,0x03..,0x99 -> no pulse.
//  5 Opcode 0xEB -> cmd_error pulse, SO stays disabled until ce_n high; next READ works.
//  6 Write at 0x3FF two bytes 11 22 (ADDR_BITS=10) -> 0x3FF=11, 0x000=22; ce_n raised after 4 bits of
//    3rd byte -> 0x001 unchanged; reset_n pulse mid-read -> so_oe 0 immediately.

Source files
------------

// File: rtl/psram_spi_responder_pkg.sv
// psram_spi_responder_pkg: opcodes, FSM states and ID-byte helper for the PSRAM SPI responder.
package psram_spi_responder_pkg;

    localparam logic [7:0] OP_READ      = 8'h03;
    localparam logic [7:0] OP_FAST_READ = 8'h0B;
    localparam logic [7:0] OP_WRITE     = 8'h02;
    localparam logic [7:0] OP_READ_ID   = 8'h9F;
    localparam logic [7:0] OP_RST_EN    = 8'h66;
    localparam logic [7:0] OP_RST       = 8'h99;
    localparam int         WAIT_CYCLES  = 8;

    typedef enum logic [2:0] {IDLE, CMD, ADDR, WAIT, DIN, DOUT, IGNORE} state_e;

    // READ_ID streams MFID, KGD, then EID MSB first, repeating every 8 bytes
    function automatic logic [7:0] id_byte(input logic [2:0] idx, input logic [7:0] mfid,
                                           input logic [7:0] kgd, input logic [47:0] eid);
        logic [63:0] seq;
        seq = {mfid, kgd, eid};
        return seq[{3'd7 - idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/psram_spi_responder_spi_edge_sync.sv
// psram_spi_responder_spi_edge_sync: 2-FF synchronizers for sclk/ce_n/si and sclk edge pulses.
module psram_spi_responder_spi_edge_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sclk_i,
    input  logic ce_n_i,
    input  logic si_i,
    output logic ce_n_o,
    output logic si_o,
    output logic rise_o,
    output logic fall_o
);

    logic [2:0] sclk_q;
    logic [1:0] ce_q;
    logic [1:0] si_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sclk_q <= '0;
            ce_q   <= 2'b11;
            si_q   <= '0;
        end else begin
            sclk_q <= {sclk_q[1:0], sclk_i};
            ce_q   <= {ce_q[0], ce_n_i};
            si_q   <= {si_q[0], si_i};
        end
    end

    assign ce_n_o = ce_q[1];
    assign si_o   = si_q[1];
    assign rise_o = sclk_q[1] & ~sclk_q[2];
    assign fall_o = ~sclk_q[1] & sclk_q[2];

endmodule

// File: rtl/psram_spi_responder.sv
// psram_spi_responder: 1-line SPI mode-0 PSRAM (IPS6404L-SQ) emulator over an internal byte array.
// Define PSRAM_RESP_PAGE_WRAP_EN to keep READ/WRITE bursts inside a 1 KB page like the real device.
module psram_spi_responder
    import psram_spi_responder_pkg::*;
#(
    parameter int          ADDR_BITS = 10,
    parameter logic [47:0] EID       = 48'h0,
    parameter logic [7:0]  MFID      = 8'h0D,
    parameter logic [7:0]  KGD       = 8'h5D
) (
    input  logic sysclk,
    input  logic reset_n,
    input  logic psram_sclk,
    input  logic psram_ce_n,
    input  logic psram_si,
    output logic psram_so,
    output logic psram_so_oe,
    output logic soft_reset,
    output logic cmd_error,
    output logic busy
);

`ifdef PSRAM_RESP_PAGE_WRAP_EN
    localparam int PAGE_BITS = (ADDR_BITS > 10) ? 10 : ADDR_BITS;
`else
    localparam int PAGE_BITS = ADDR_BITS;
`endif
    localparam logic [ADDR_BITS-1:0] PAGE_MASK = ADDR_BITS'((64'd1 << PAGE_BITS) - 64'd1);
    localparam logic [ADDR_BITS-1:0] ONE       = ADDR_BITS'(1);
    // shift register only keeps the address bits that matter (and at least a byte)
    localparam int SW = (ADDR_BITS > 8) ? ADDR_BITS : 8;

    function automatic logic [ADDR_BITS-1:0] next_addr(input logic [ADDR_BITS-1:0] a);
        return (a & ~PAGE_MASK) | ((a + ONE) & PAGE_MASK);
    endfunction

    logic ce_s, si_s, rise, fall;

    psram_spi_responder_spi_edge_sync u_sync (
        .clk_i  (sysclk),
        .rst_ni (reset_n),
        .sclk_i (psram_sclk),
        .ce_n_i (psram_ce_n),
        .si_i   (psram_si),
        .ce_n_o (ce_s),
        .si_o   (si_s),
        .rise_o (rise),
        .fall_o (fall)
    );

    state_e                state_q, state_d;
    logic [4:0]            cnt_q, cnt_d;
    logic [SW-2:0]         sh_q, sh_d;
    logic [ADDR_BITS-1:0]  addr_q, addr_d;
    logic [7:0]            cmd_q, cmd_d;
    logic [2:0]            idx_q, idx_d;
    logic [6:0]            dsh_q, dsh_d;
    logic                  load_q, load_d;
    logic                  so_q, so_d;
    logic                  oe_q, oe_d;
    logic                  armed_q, armed_d;
    logic                  srst_q, srst_d;
    logic                  cerr_q, cerr_d;

    logic [SW-1:0]         shv;
    logic                  hdr_op;
    logic [7:0]            byte_in;
    logic [7:0]            rdata_q;
    logic                  ram_we, ram_re;
    logic [ADDR_BITS-1:0]  ram_a;
    logic [7:0]            ram_wd;
    logic [7:0]            mem [2**ADDR_BITS];

    assign shv     = {sh_q, si_s};
    assign hdr_op  = shv[7:0] inside {OP_READ, OP_FAST_READ, OP_WRITE, OP_READ_ID};
    assign byte_in = (cmd_q == OP_READ_ID) ? id_byte(idx_q, MFID, KGD, EID) : rdata_q;

    always_ff @(posedge sysclk) begin
        if (ram_we) mem[ram_a] <= ram_wd;
        if (ram_re) rdata_q <= mem[ram_a];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        addr_d  = addr_q;
        cmd_d   = cmd_q;
        idx_d   = idx_q;
        dsh_d   = dsh_q;
        load_d  = load_q;
        so_d    = so_q;
        oe_d    = oe_q;
        armed_d = armed_q;
        srst_d  = 1'b0;
        cerr_d  = 1'b0;
        ram_we  = 1'b0;
        ram_re  = 1'b0;
        ram_a   = addr_q;
        ram_wd  = shv[7:0];
        if (ce_s) begin
            state_d = IDLE;
            cnt_d   = '0;
            load_d  = 1'b0;
            oe_d    = 1'b0;
            so_d    = 1'b0;
        end else if (rise) begin
            cnt_d = cnt_q + 5'd1;
            sh_d  = shv[SW-2:0];
            case (state_q)
                // IDLE also shifts so a first rise arriving with ce_n is not lost
                IDLE, CMD: begin
                    state_d = CMD;
                    if (cnt_q == 5'd7) begin
                        cnt_d   = '0;
                        cmd_d   = shv[7:0];
                        armed_d = shv[7:0] == OP_RST_EN;
                        srst_d  = shv[7:0] == OP_RST && armed_q;
                        cerr_d  = !hdr_op && shv[7:0] != OP_RST_EN && shv[7:0] != OP_RST;
                        state_d = hdr_op ? ADDR : IGNORE;
                    end
                end
                ADDR: if (cnt_q == 5'd23) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    load_d  = cmd_q == OP_READ || cmd_q == OP_READ_ID;
                    ram_re  = cmd_q == OP_READ;
                    ram_a   = shv[ADDR_BITS-1:0];
                    addr_d  = (cmd_q == OP_READ) ? next_addr(shv[ADDR_BITS-1:0]) : shv[ADDR_BITS-1:0];
                    state_d = (cmd_q == OP_FAST_READ) ? WAIT : (cmd_q == OP_WRITE) ? DIN : DOUT;
                end
                WAIT: if (cnt_q == 5'(WAIT_CYCLES - 1)) begin
                    cnt_d   = '0;
                    load_d  = 1'b1;
                    ram_re  = 1'b1;
                    addr_d  = next_addr(addr_q);
                    state_d = DOUT;
                end
                DIN: if (cnt_q == 5'd7) begin
                    cnt_d  = '0;
                    ram_we = 1'b1;
                    addr_d = next_addr(addr_q);
                end
                // prefetch the next byte on the last bit so it is ready for the following fall
                DOUT: if (cnt_q == 5'd7) begin
                    cnt_d  = '0;
                    load_d = 1'b1;
                    idx_d  = idx_q + 3'd1;
                    ram_re = cmd_q != OP_READ_ID;
                    addr_d = next_addr(addr_q);
                end
                default: ;
            endcase
        end else if (fall && state_q == DOUT) begin
            oe_d   = 1'b1;
            so_d   = load_q ? byte_in[7] : dsh_q[6];
            dsh_d  = load_q ? byte_in[6:0] : {dsh_q[5:0], 1'b0};
            load_d = 1'b0;
        end
    end

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            addr_q  <= '0;
            cmd_q   <= '0;
            idx_q   <= '0;
            dsh_q   <= '0;
            load_q  <= 1'b0;
            so_q    <= 1'b0;
            oe_q    <= 1'b0;
            armed_q <= 1'b0;
            srst_q  <= 1'b0;
            cerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            addr_q  <= addr_d;
            cmd_q   <= cmd_d;
            idx_q   <= idx_d;
            dsh_q   <= dsh_d;
            load_q  <= load_d;
            so_q    <= so_d;
            oe_q    <= oe_d;
            armed_q <= armed_d;
            srst_q  <= srst_d;
            cerr_q  <= cerr_d;
        end
    end

    assign psram_so    = so_q;
    assign psram_so_oe = oe_q;
    assign soft_reset  = srst_q;
    assign cmd_error   = cerr_q;
    assign busy        = ~ce_s;

endmodule
